i2c_write_arbiter: RTL and testbench

- Shares one i2c_write_master instance between N_REQ independent requesters, for example the OLED configuration sequencer and a second I2C peripheral driver.
- Grants the bus round-robin, one whole transaction at a time. A transaction is START, address, data bytes, then STOP on the byte marked last.
- Muxes the granted requester's address, data and last flag into the master. Demuxes the master's done and failure pulses back to that requester.
- Provides a watchdog that flags a hung master.

---
 rtl/i2c_pkg.sv | 21 ++
 rtl/rr_pick.sv | 31 +++
 rtl/i2c_write_arbiter.sv | 158 +++++++++++++++
 tb/tb_i2c_write_arbiter.sv | 535 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C write path.
// Arbiter state encoding, bus widths, known slave addresses.
package i2c_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADDR    = 2'd1,
    DATA    = 2'd2,
    RELEASE = 2'd3
  } t_arb_state;

  localparam int I2C_ADDR_WIDTH = 7;
  localparam int I2C_DATA_WIDTH = 8;

  localparam logic [6:0] SSD1306_ADDR = 7'h3C;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner search over a request vector.
// Search starts one past the pointer and wraps around.
module rr_pick
  import i2c_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  logic [IW-1:0] j;

  // first requester found after the pointer wins
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    j       = i_ptr;
    for (int i = 0; i < N; i++) begin
      j = (j == IW'(N - 1)) ? '0 : j + 1'b1;
      if (!o_valid && i_req[j]) begin
        o_idx   = j;
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_write_arbiter.sv
// Shares one I2C write master between several requesters.
// Round-robin per transaction, with a hung-master watchdog.
module i2c_write_arbiter
  import i2c_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int ADDR_WIDTH = I2C_ADDR_WIDTH,
  parameter int DATA_WIDTH = I2C_DATA_WIDTH,
  parameter int WDT_CYCLES = 65535
) (
  input  logic                        i_clk,
  input  logic                        i_arst,
  input  logic [N_REQ-1:0]            i_req,
  input  logic [N_REQ*ADDR_WIDTH-1:0] i_req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] i_req_data,
  input  logic [N_REQ-1:0]            i_req_last,
  output logic [N_REQ-1:0]            o_gnt,
  output logic [N_REQ-1:0]            o_addr_done,
  output logic [N_REQ-1:0]            o_data_done,
  output logic [N_REQ-1:0]            o_fail,
  output logic                        o_busy,
  output logic                        o_wdt_error,
  output logic                        o_m_start,
  output logic                        o_m_last,
  output logic [ADDR_WIDTH-1:0]       o_m_addr,
  output logic [DATA_WIDTH-1:0]       o_m_data,
  input  logic                        i_m_ready,
  input  logic                        i_m_addr_done,
  input  logic                        i_m_data_done,
  input  logic                        i_m_rw_failure
);

  localparam int IW = idx_w(N_REQ);
  localparam int CW = $clog2(WDT_CYCLES + 1);

  t_arb_state state_q, state_d;

  logic [IW-1:0]         owner_q, owner_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [IW-1:0]         win_idx;
  logic                  win_vld;
  logic [N_REQ-1:0]      own_oh;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_last;
  logic [CW-1:0]         wdt_q;
  logic                  wdt_err_q;
  logic                  m_event;

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .i_req   (i_req),
    .i_ptr   (ptr_q),
    .o_idx   (win_idx),
    .o_valid (win_vld)
  );

  assign own_oh = (state_q != IDLE) ?
                  (N_REQ'(1) << owner_q) : '0;

  assign m_event = i_m_addr_done | i_m_data_done |
                   i_m_rw_failure;

  // route the owner's address, byte and last flag
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_last = 1'b0;
    if (state_q != IDLE) begin
      sel_addr = i_req_addr[owner_q*ADDR_WIDTH +: ADDR_WIDTH];
      sel_data = i_req_data[owner_q*DATA_WIDTH +: DATA_WIDTH];
      sel_last = i_req_last[owner_q];
    end
  end

  // next state and forwarded master events
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    o_m_start   = 1'b0;
    o_addr_done = '0;
    o_data_done = '0;
    o_fail      = '0;
    unique case (state_q)
      IDLE: begin
        if (i_m_ready && win_vld) begin
          owner_d = win_idx;
          state_d = ADDR;
        end
      end
      ADDR: begin
        o_m_start = i_m_ready;
        if (i_m_rw_failure) begin
          o_fail  = own_oh;
          state_d = RELEASE;
        end else if (i_m_addr_done) begin
          o_addr_done = own_oh;
          state_d     = DATA;
        end
      end
      DATA: begin
        if (i_m_rw_failure) begin
          o_fail  = own_oh;
          state_d = RELEASE;
        end else if (i_m_data_done) begin
          o_data_done = own_oh;
          if (sel_last) state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (i_m_ready) begin
          ptr_d   = owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // arbitration state, owner and priority pointer
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= IW'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  // cycles since last master event; sticky overflow flag
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      wdt_q     <= '0;
      wdt_err_q <= 1'b0;
    end else begin
      if (state_q == IDLE || m_event)
        wdt_q <= '0;
      else if (wdt_q != CW'(WDT_CYCLES))
        wdt_q <= wdt_q + 1'b1;
      if (wdt_q == CW'(WDT_CYCLES))
        wdt_err_q <= 1'b1;
    end
  end

  assign o_gnt       = own_oh;
  assign o_busy      = (state_q != IDLE);
  assign o_wdt_error = wdt_err_q;
  assign o_m_addr    = sel_addr;
  assign o_m_data    = sel_data;
  assign o_m_last    = sel_last;

endmodule

// File: tb/tb_i2c_write_arbiter.sv
// Bench for i2c_write_arbiter: requester and master models,
// grant and byte scoreboards, one task per scenario.
module tb_i2c_write_arbiter;
  import i2c_pkg::*;

  localparam int N   = 2;
  localparam int AW  = 7;
  localparam int DW  = 8;
  localparam int WDT = 16;

  logic            i_clk;
  logic            i_arst;
  logic [N-1:0]    i_req;
  logic [N*AW-1:0] i_req_addr;
  logic [N*DW-1:0] i_req_data;
  logic [N-1:0]    i_req_last;
  logic [N-1:0]    o_gnt;
  logic [N-1:0]    o_addr_done;
  logic [N-1:0]    o_data_done;
  logic [N-1:0]    o_fail;
  logic            o_busy;
  logic            o_wdt_error;
  logic            o_m_start;
  logic            o_m_last;
  logic [AW-1:0]   o_m_addr;
  logic [DW-1:0]   o_m_data;
  logic            i_m_ready;
  logic            i_m_addr_done;
  logic            i_m_data_done;
  logic            i_m_rw_failure;

  i2c_write_arbiter #(
    .N_REQ      (N),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .WDT_CYCLES (WDT)
  ) dut (
    .i_clk          (i_clk),
    .i_arst         (i_arst),
    .i_req          (i_req),
    .i_req_addr     (i_req_addr),
    .i_req_data     (i_req_data),
    .i_req_last     (i_req_last),
    .o_gnt          (o_gnt),
    .o_addr_done    (o_addr_done),
    .o_data_done    (o_data_done),
    .o_fail         (o_fail),
    .o_busy         (o_busy),
    .o_wdt_error    (o_wdt_error),
    .o_m_start      (o_m_start),
    .o_m_last       (o_m_last),
    .o_m_addr       (o_m_addr),
    .o_m_data       (o_m_data),
    .i_m_ready      (i_m_ready),
    .i_m_addr_done  (i_m_addr_done),
    .i_m_data_done  (i_m_data_done),
    .i_m_rw_failure (i_m_rw_failure)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  typedef struct packed {
    logic [7:0] d;
    logic       last;
  } byte_t;

  typedef struct packed {
    logic [1:0] g;
    logic [6:0] a;
    logic [7:0] d;
    logic       last;
  } exp_t;

  typedef enum int {M_IDLE, M_ADDR, M_DATA, M_STOP} mst_t;

  byte_t      rq [N][$];
  logic [6:0] ra [N];
  exp_t       eq [$];
  logic [1:0] gq [$];

  int   errors = 0;
  int   checks = 0;
  bit   pop_p [N];
  bit   ab_p [N];
  bit   drop [N];
  bit   hang;
  bit   nack_next;
  mst_t mst;
  int   dly;
  logic [6:0] maddr;
  logic [1:0] prev_gnt;
  logic prev_start;
  int   starts;
  int   ad_cnt [N];
  int   dd_cnt [N];
  int   fl_cnt [N];

  task automatic clear_models();
    for (int k = 0; k < N; k++) begin
      rq[k].delete();
      pop_p[k] = 1'b0;
      ab_p[k]  = 1'b0;
      drop[k]  = 1'b0;
      ra[k]    = '0;
    end
    eq.delete();
    gq.delete();
    hang           = 1'b0;
    nack_next      = 1'b0;
    mst            = M_IDLE;
    dly            = 0;
    maddr          = '0;
    prev_gnt       = '0;
    prev_start     = 1'b0;
    i_req          = '0;
    i_req_last     = '0;
    i_req_addr     = '0;
    i_req_data     = '0;
    i_m_ready      = 1'b1;
    i_m_addr_done  = 1'b0;
    i_m_data_done  = 1'b0;
    i_m_rw_failure = 1'b0;
  endtask

  task automatic add_txn(input int k, input logic [6:0] a,
                         input int n, input logic [7:0] b0,
                         input logic [7:0] b1,
                         input logic [7:0] b2, input bit nack);
    logic [7:0] bb [3];
    bb = '{b0, b1, b2};
    ra[k] = a;
    gq.push_back(2'(1 << k));
    for (int i = 0; i < n; i++) begin
      rq[k].push_back('{d: bb[i], last: (i == n - 1)});
      if (!nack)
        eq.push_back('{g: 2'(1 << k), a: a, d: bb[i],
                       last: (i == n - 1)});
    end
  endtask

  task automatic step();
    byte_t b;
    bit    fin;
    exp_t  e;
    @(negedge i_clk);
    for (int k = 0; k < N; k++) begin
      if (pop_p[k] && rq[k].size() != 0) b = rq[k].pop_front();
      if (ab_p[k]) begin
        fin = 1'b0;
        while (!fin && rq[k].size() != 0) begin
          b   = rq[k].pop_front();
          fin = b.last;
        end
      end
      pop_p[k] = 1'b0;
      ab_p[k]  = 1'b0;
      i_req[k] = (rq[k].size() != 0) && !drop[k];
      i_req_addr[k*AW +: AW] = ra[k];
      if (rq[k].size() != 0) begin
        i_req_data[k*DW +: DW] = rq[k][0].d;
        i_req_last[k]          = rq[k][0].last;
      end else begin
        i_req_data[k*DW +: DW] = '0;
        i_req_last[k]          = 1'b0;
      end
    end
    i_m_addr_done  = 1'b0;
    i_m_data_done  = 1'b0;
    i_m_rw_failure = 1'b0;
    case (mst)
      M_IDLE: i_m_ready = 1'b1;
      M_ADDR: begin
        i_m_ready = 1'b0;
        if (dly != 0) dly--;
        else if (nack_next) begin
          i_m_rw_failure = 1'b1;
          nack_next      = 1'b0;
          mst            = M_STOP;
          dly            = 1;
        end else begin
          i_m_addr_done = 1'b1;
          mst           = M_DATA;
          dly           = 2;
        end
      end
      M_DATA: begin
        if (!hang) begin
          if (dly != 0) dly--;
          else begin
            i_m_data_done = 1'b1;
            dly           = 2;
          end
        end
      end
      default: begin
        if (dly != 0) dly--;
        else begin
          i_m_ready = 1'b1;
          mst       = M_IDLE;
        end
      end
    endcase
    #1;
    if (o_m_start && !prev_start) starts++;
    prev_start = o_m_start;
    if (mst == M_IDLE && o_m_start) begin
      maddr = o_m_addr;
      mst   = M_ADDR;
      dly   = 1;
    end
    if (o_gnt != 0 && prev_gnt == 0) begin
      checks++;
      if (gq.size() == 0) begin
        errors++;
        $display("FAIL grant_unexpected got=%b", o_gnt);
      end else if (o_gnt !== gq[0]) begin
        errors++;
        $display("FAIL grant_order got=%b want=%b",
                 o_gnt, gq[0]);
        void'(gq.pop_front());
      end else void'(gq.pop_front());
    end
    if (prev_gnt != 0 && o_gnt != 0) begin
      checks++;
      if (o_gnt !== prev_gnt) begin
        errors++;
        $display("FAIL grant_gap got=%b prev=%b",
                 o_gnt, prev_gnt);
      end
    end
    prev_gnt = o_gnt;
    checks++;
    if (o_busy !== (o_gnt != 0)) begin
      errors++;
      $display("FAIL busy got=%b gnt=%b", o_busy, o_gnt);
    end
    for (int k = 0; k < N; k++) begin
      if (o_addr_done[k]) ad_cnt[k]++;
      if (o_data_done[k]) begin
        dd_cnt[k]++;
        pop_p[k] = 1'b1;
      end
      if (o_fail[k]) begin
        fl_cnt[k]++;
        ab_p[k] = 1'b1;
      end
    end
    if (o_data_done != 0) begin
      checks++;
      if (eq.size() == 0) begin
        errors++;
        $display("FAIL data_unexpected dd=%b data=%h",
                 o_data_done, o_m_data);
      end else begin
        e = eq.pop_front();
        if (o_data_done !== e.g || maddr !== e.a ||
            o_m_data !== e.d || o_m_last !== e.last) begin
          errors++;
          $display("FAIL data_sb got=%b/%h/%h/%b want=%b/%h/%h/%b",
                   o_data_done, maddr, o_m_data, o_m_last,
                   e.g, e.a, e.d, e.last);
        end
      end
    end
    if (mst == M_DATA && i_m_data_done && o_m_last) begin
      mst = M_STOP;
      dly = 1;
    end
  endtask

  function automatic bit all_idle();
    return rq[0].size() == 0 && rq[1].size() == 0 &&
           !o_busy && mst == M_IDLE;
  endfunction

  task automatic run_until_idle(input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (n < 400 && !all_idle());
    checks++;
    if (!all_idle()) begin
      errors++;
      $display("FAIL %s_timeout busy=%b gnt=%b", tag, o_busy, o_gnt);
    end
  endtask

  task automatic check_sb(input string tag);
    checks++;
    if (eq.size() != 0 || gq.size() != 0) begin
      errors++;
      $display("FAIL %s_sb_left data=%0d grants=%0d want 0/0",
               tag, eq.size(), gq.size());
    end
  endtask

  task automatic do_reset();
    i_arst = 1'b1;
    clear_models();
    step();
    step();
    i_arst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    step();
    checks++;
    if (o_gnt !== 0 || o_busy !== 0 || o_wdt_error !== 0 ||
        o_m_start !== 0 || o_m_last !== 0) begin
      errors++;
      $display("FAIL reset_ctl gnt=%b busy=%b wdt=%b st=%b lst=%b",
               o_gnt, o_busy, o_wdt_error, o_m_start, o_m_last);
    end
    checks++;
    if (o_m_addr !== 0 || o_m_data !== 0 || o_addr_done !== 0 ||
        o_data_done !== 0 || o_fail !== 0) begin
      errors++;
      $display("FAIL reset_data addr=%h data=%h ad=%b dd=%b f=%b",
               o_m_addr, o_m_data, o_addr_done, o_data_done, o_fail);
    end
  endtask

  task automatic test_single();
    int ad0, dd0, st0;
    ad0 = ad_cnt[0];
    dd0 = dd_cnt[0];
    st0 = starts;
    add_txn(0, SSD1306_ADDR, 2, 8'h00, 8'hAE, 8'h00, 1'b0);
    step();
    checks++;
    if (o_gnt !== 2'b00) begin
      errors++;
      $display("FAIL single_lat0 got=%b want=00", o_gnt);
    end
    step();
    checks++;
    if (o_gnt !== 2'b01) begin
      errors++;
      $display("FAIL single_lat1 got=%b want=01", o_gnt);
    end
    run_until_idle("single");
    checks++;
    if (ad_cnt[0] - ad0 != 1 || dd_cnt[0] - dd0 != 2 ||
        starts - st0 != 1) begin
      errors++;
      $display("FAIL single_counts ad=%0d dd=%0d st=%0d want 1/2/1",
               ad_cnt[0] - ad0, dd_cnt[0] - dd0, starts - st0);
    end
    checks++;
    if (o_gnt !== 2'b00) begin
      errors++;
      $display("FAIL single_end_gnt got=%b want=00", o_gnt);
    end
    check_sb("single");
  endtask

  task automatic test_both();
    int a0, a1;
    do_reset();
    a0 = ad_cnt[0];
    a1 = ad_cnt[1];
    add_txn(0, 7'h3C, 1, 8'h10, 8'h00, 8'h00, 1'b0);
    add_txn(1, 7'h51, 1, 8'h20, 8'h00, 8'h00, 1'b0);
    add_txn(0, 7'h3C, 1, 8'h11, 8'h00, 8'h00, 1'b0);
    add_txn(1, 7'h51, 1, 8'h21, 8'h00, 8'h00, 1'b0);
    run_until_idle("both");
    checks++;
    if (ad_cnt[0] - a0 != 2 || ad_cnt[1] - a1 != 2) begin
      errors++;
      $display("FAIL both_addr_done got=%0d/%0d want=2/2",
               ad_cnt[0] - a0, ad_cnt[1] - a1);
    end
    check_sb("both");
  endtask

  task automatic test_nack();
    int f1, a1, n;
    f1 = fl_cnt[1];
    a1 = ad_cnt[1];
    nack_next = 1'b1;
    add_txn(1, 7'h50, 2, 8'h11, 8'h22, 8'h00, 1'b1);
    n = 0;
    do begin
      step();
      n++;
    end while (n < 20 && o_gnt == 0);
    add_txn(0, 7'h3C, 1, 8'h5A, 8'h00, 8'h00, 1'b0);
    run_until_idle("nack");
    checks++;
    if (fl_cnt[1] - f1 != 1 || ad_cnt[1] - a1 != 0) begin
      errors++;
      $display("FAIL nack_pulses fail=%0d ad=%0d want=1/0",
               fl_cnt[1] - f1, ad_cnt[1] - a1);
    end
    check_sb("nack");
  endtask

  task automatic test_drop();
    int d0, n, bad;
    d0  = dd_cnt[0];
    bad = 0;
    add_txn(0, 7'h3C, 3, 8'hA1, 8'hA2, 8'hA3, 1'b0);
    n = 0;
    do begin
      step();
      n++;
    end while (n < 60 && dd_cnt[0] == d0);
    drop[0] = 1'b1;
    n = 0;
    do begin
      step();
      n++;
      if (o_busy && o_gnt !== 2'b01) bad++;
    end while (n < 400 && !all_idle());
    drop[0] = 1'b0;
    checks++;
    if (bad != 0 || dd_cnt[0] - d0 != 3) begin
      errors++;
      $display("FAIL drop_hold badgnt=%0d dd=%0d want=0/3",
               bad, dd_cnt[0] - d0);
    end
    check_sb("drop");
  endtask

  task automatic test_wdt();
    int a1, n;
    a1 = ad_cnt[1];
    checks++;
    if (o_wdt_error !== 1'b0) begin
      errors++;
      $display("FAIL wdt_pre got=%b want=0", o_wdt_error);
    end
    hang = 1'b1;
    add_txn(1, 7'h3D, 2, 8'h55, 8'h66, 8'h00, 1'b0);
    n = 0;
    do begin
      step();
      n++;
    end while (n < 40 && ad_cnt[1] == a1);
    repeat (8) step();
    checks++;
    if (o_wdt_error !== 1'b0) begin
      errors++;
      $display("FAIL wdt_early got=%b want=0", o_wdt_error);
    end
    n = 0;
    do begin
      step();
      n++;
    end while (n < 40 && o_wdt_error !== 1'b1);
    checks++;
    if (o_wdt_error !== 1'b1) begin
      errors++;
      $display("FAIL wdt_set got=%b want=1", o_wdt_error);
    end
    hang = 1'b0;
    run_until_idle("wdt");
    add_txn(0, 7'h3C, 1, 8'h77, 8'h00, 8'h00, 1'b0);
    run_until_idle("wdt_after");
    checks++;
    if (o_wdt_error !== 1'b1) begin
      errors++;
      $display("FAIL wdt_sticky got=%b want=1", o_wdt_error);
    end
    check_sb("wdt");
  endtask

  task automatic test_reset_mid();
    int d0, n;
    d0 = dd_cnt[0];
    add_txn(0, 7'h3C, 3, 8'h01, 8'h02, 8'h03, 1'b0);
    n = 0;
    do begin
      step();
      n++;
    end while (n < 60 && dd_cnt[0] == d0);
    @(negedge i_clk);
    i_arst = 1'b1;
    #1;
    checks++;
    if (o_gnt !== 0 || o_busy !== 0 || o_m_start !== 0 ||
        o_m_addr !== 0 || o_m_data !== 0 || o_m_last !== 0 ||
        o_wdt_error !== 0 || o_data_done !== 0) begin
      errors++;
      $display("FAIL rst_mid gnt=%b busy=%b st=%b a=%h d=%h w=%b",
               o_gnt, o_busy, o_m_start, o_m_addr, o_m_data,
               o_wdt_error);
    end
    clear_models();
    step();
    step();
    i_arst = 1'b0;
    add_txn(0, 7'h3C, 1, 8'hC0, 8'h00, 8'h00, 1'b0);
    add_txn(1, 7'h52, 1, 8'hC1, 8'h00, 8'h00, 1'b0);
    n = 0;
    do begin
      step();
      n++;
    end while (n < 20 && o_gnt == 0);
    checks++;
    if (o_gnt !== 2'b01) begin
      errors++;
      $display("FAIL rst_first_gnt got=%b want=01", o_gnt);
    end
    run_until_idle("rst_mid");
    check_sb("rst_mid");
  endtask

  initial begin
    starts = 0;
    for (int k = 0; k < N; k++) begin
      ad_cnt[k] = 0;
      dd_cnt[k] = 0;
      fl_cnt[k] = 0;
    end
    i_arst = 1'b1;
    clear_models();
    test_reset();
    test_single();
    test_both();
    test_nack();
    test_drop();
    test_wdt();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
